// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   arb_state_e          - arbiter FSM state encoding (also exported on o_state)
//   DEFAULT_CLKS_PER_BIT - UART bit period in clock cycles (115200 baud at 75 MHz)
//   TIMEOUT_MULT         - watchdog limit expressed in bit periods
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 651;
  // 16 bit periods: one full 10-bit frame plus generous slack.
  localparam int TIMEOUT_MULT         = 16;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the index
// after ptr_i and wraps from N-1 to 0, so the requester at ptr_i itself has
// the lowest priority.
// Ports:
//   req_i [N-1:0]  - request vector
//   ptr_i [PW-1:0] - index of the last released owner
//   gnt_o [N-1:0]  - one-hot grant, all zeros when req_i is zero
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [PW:0] cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!found && req_i[cand[PW-1:0]]) begin
        gnt_o[cand[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// An owner keeps the transmitter for a whole packet (until a byte with
// i_req_last=1 has been sent); a watchdog reclaims it if the UART never
// reports done or the owner stalls mid-packet.
//
// Handshake: requester k's byte is consumed in the cycle where
// i_req_valid[k] and o_req_ready[k] are both high. o_req_ready is a one-cycle
// one-hot pulse issued only in SEND; a requester may drop valid at any time
// without penalty because valids are only looked at during arbitration.
//
// Ports:
//   i_clk, i_rst_n         - clock, asynchronous active-low reset
//   i_req_valid/_byte/_last - per-requester byte stream (byte k in [8k+7:8k])
//   o_req_ready            - one-hot accept pulse
//   o_TX_Byte, o_TX_DV     - load interface to the UART transmitter
//   i_TX_Done              - transmitter byte-complete strobe
//   o_grant                - one-hot current owner, zero when unowned
//   o_busy                 - FSM not in IDLE
//   o_timeout              - one-cycle watchdog pulse
//   o_state                - current FSM state (arb_state_e encoding)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = TIMEOUT_MULT * CLKS_PER_BIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_byte,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [7:0]             o_TX_Byte,
  output logic                   o_TX_DV,
  input  logic                   i_TX_Done,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic [1:0]             o_state
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CLKS + 1);
  // The pulse fires in the TIMEOUT_CLKS-th cycle spent in the current state.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CLKS - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 last_q, last_d;
  logic [WDW-1:0]       wd_q, wd_d;

  logic [NUM_REQ-1:0]   rr_gnt;
  logic [PW-1:0]        owner_idx;
  logic [7:0]           owner_byte;
  logic                 owner_last;
  logic                 owner_valid;
  logic                 wd_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // Decode the registered one-hot owner into index / byte / last.
  always_comb begin
    owner_idx  = '0;
    owner_byte = 8'h00;
    owner_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        owner_idx  = PW'(k);
        owner_byte = i_req_byte[8*k +: 8];
        owner_last = i_req_last[k];
      end
    end
  end

  assign owner_valid = |(i_req_valid & grant_q);
  assign wd_hit      = (wd_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    o_TX_DV     = 1'b0;
    o_TX_Byte   = 8'h00;
    o_req_ready = '0;
    o_timeout   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          grant_d = rr_gnt;
          state_d = SEND;
        end
      end

      SEND: begin
        o_TX_DV     = 1'b1;
        o_TX_Byte   = owner_byte;
        o_req_ready = grant_q;
        last_d      = owner_last;
        state_d     = WAIT_DONE;
      end

      // Done is checked before the watchdog so a coincident done wins.
      WAIT_DONE: begin
        if (i_TX_Done) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = owner_idx;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else if (wd_hit) begin
          o_timeout = 1'b1;
          grant_d   = '0;
          ptr_d     = owner_idx;
          state_d   = IDLE;
        end
      end

      // Only the owner may continue; everyone else waits for release.
      HOLD: begin
        if (owner_valid) begin
          state_d = SEND;
        end else if (wd_hit) begin
          o_timeout = 1'b1;
          grant_d   = '0;
          ptr_d     = owner_idx;
          state_d   = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    // Watchdog runs only while staying in WAIT_DONE or HOLD; any state
    // change (including HOLD->SEND->WAIT_DONE) restarts it from zero.
    if ((state_d == state_q) && ((state_q == WAIT_DONE) || (state_q == HOLD))) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      last_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);
  assign o_state = state_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CLKS=20).
// Requester models replay per-requester byte lists; a UART model returns
// i_TX_Done a programmable number of cycles after each load. Every expected
// transmit beat {ready, grant, byte} is queued when stimulus is issued and
// the monitor pops one entry per o_TX_DV.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 4;
  localparam int TO  = 20;

  logic            i_clk;
  logic            i_rst_n;
  logic [NR-1:0]   i_req_valid;
  logic [8*NR-1:0] i_req_byte;
  logic [NR-1:0]   i_req_last;
  logic [NR-1:0]   o_req_ready;
  logic [7:0]      o_TX_Byte;
  logic            o_TX_DV;
  logic            i_TX_Done;
  logic [NR-1:0]   o_grant;
  logic            o_busy;
  logic            o_timeout;
  logic [1:0]      o_state;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_byte  (i_req_byte),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Done   (i_TX_Done),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout),
    .o_state     (o_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  rq_byte [NR][8];
  logic        rq_last [NR][8];
  int          rq_cnt  [NR];
  int          rq_rd   [NR];
  logic        auto_done;
  int          done_lat;
  int          tmo_cnt  = 0;
  int          tmo_cyc  = 0;
  int          dv_cyc   = 0;
  int          done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_req(input int k, input logic [7:0] b, input logic l);
    rq_byte[k][rq_cnt[k]] = b;
    rq_last[k][rq_cnt[k]] = l;
    rq_cnt[k]++;
  endtask

  task automatic expect_beat(input int k, input logic [7:0] b);
    logic [3:0] oh;
    oh = 4'(1 << k);
    exp_q.push_back({oh, oh, b});
  endtask

  // ---------------- requester driver ----------------
  initial begin
    i_req_valid = '0;
    i_req_byte  = '0;
    i_req_last  = '0;
    for (int k = 0; k < NR; k++) begin
      rq_cnt[k] = 0;
      rq_rd[k]  = 0;
    end
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < NR; k++) begin
        if (i_req_valid[k] && o_req_ready[k]) rq_rd[k]++;
      end
      @(posedge i_clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (rq_rd[k] < rq_cnt[k]) begin
          i_req_valid[k]       = 1'b1;
          i_req_byte[8*k +: 8] = rq_byte[k][rq_rd[k]];
          i_req_last[k]        = rq_last[k][rq_rd[k]];
        end else begin
          i_req_valid[k]       = 1'b0;
          i_req_byte[8*k +: 8] = 8'h00;
          i_req_last[k]        = 1'b0;
        end
      end
    end
  end

  // ---------------- UART transmitter model ----------------
  initial begin
    i_TX_Done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_TX_DV && auto_done) begin
        repeat (done_lat) @(posedge i_clk);
        #1 i_TX_Done = 1'b1;
        @(posedge i_clk);
        #1 i_TX_Done = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge i_clk);
      if (i_TX_Done) done_cyc = cyc;
      if (o_timeout) begin
        tmo_cnt++;
        tmo_cyc = cyc;
      end
      if (o_TX_DV) begin
        dv_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv: byte %0h grant %0h with nothing expected (cycle %0d)",
                   o_TX_Byte, o_grant, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({o_req_ready, o_grant, o_TX_Byte} !== e) begin
            errors++;
            $display("FAIL tx_beat: got ready/grant/byte %0h expected %0h (cycle %0d)",
                     {o_req_ready, o_grant, o_TX_Byte}, e, cyc);
          end
        end
      end
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < max) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size() == 0 && !o_busy), 32'd1);
  endtask

  task automatic wait_beats(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_beats"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tmo(input string name, input int max);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_timeout && n < max);
    chk({name, "_tmo_seen"}, 32'(o_timeout), 32'd1);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"},    32'(o_busy),      32'd0);
    chk({name, "_grant"},   32'(o_grant),     32'd0);
    chk({name, "_dv"},      32'(o_TX_DV),     32'd0);
    chk({name, "_ready"},   32'(o_req_ready), 32'd0);
    chk({name, "_timeout"}, 32'(o_timeout),   32'd0);
    chk({name, "_byte"},    32'(o_TX_Byte),   32'd0);
    chk({name, "_state"},   32'(o_state),     32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    i_rst_n   = 1'b0;
    auto_done = 1'b1;
    done_lat  = 3;

    // Reset with req0 already valid: nothing may be sent while held.
    add_req(0, 8'hF5, 1'b1);
    repeat (3) @(negedge i_clk);
    chk_reset_outputs("por");
    expect_beat(0, 8'hF5);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("first_idle_dv", 32'(o_TX_DV), 32'd0);
    chk("first_idle_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    chk("first_latency_dv", 32'(o_TX_DV), 32'd1);
    chk("first_send_busy", 32'(o_busy), 32'd1);
    wait_drain("single", 50);
    chk("single_grant_released", 32'(o_grant), 32'd0);

    // All four valid: A0..A3 in order, pointer wraps, A0 again.
    do_reset();
    add_req(0, 8'hA0, 1'b1);
    add_req(1, 8'hA1, 1'b1);
    add_req(2, 8'hA2, 1'b1);
    add_req(3, 8'hA3, 1'b1);
    add_req(0, 8'hA0, 1'b1);
    expect_beat(0, 8'hA0);
    expect_beat(1, 8'hA1);
    expect_beat(2, 8'hA2);
    expect_beat(3, 8'hA3);
    expect_beat(0, 8'hA0);
    wait_drain("rr4", 200);

    // Multi-byte packet keeps ownership while req2 waits.
    do_reset();
    add_req(1, 8'hDC, 1'b0);
    add_req(1, 8'hF0, 1'b0);
    add_req(1, 8'hAB, 1'b1);
    add_req(2, 8'h55, 1'b1);
    expect_beat(1, 8'hDC);
    expect_beat(1, 8'hF0);
    expect_beat(1, 8'hAB);
    expect_beat(2, 8'h55);
    wait_drain("packet", 200);

    // Owner stalls in HOLD: watchdog releases, req0 served next.
    do_reset();
    t0 = tmo_cnt;
    add_req(3, 8'h3D, 1'b0);
    expect_beat(3, 8'h3D);
    wait_beats("hold", 20);
    add_req(0, 8'h11, 1'b1);
    expect_beat(0, 8'h11);
    wait_tmo("hold", 60);
    chk("hold_tmo_state", 32'(o_state), 32'd3);
    chk("hold_tmo_grant", 32'(o_grant), 32'h8);
    chk("hold_tmo_cycle", 32'(cyc), 32'(done_cyc + TO));
    @(negedge i_clk);
    chk("hold_released_grant", 32'(o_grant), 32'd0);
    chk("hold_released_busy", 32'(o_busy), 32'd0);
    wait_drain("hold", 50);
    chk("hold_tmo_count", 32'(tmo_cnt - t0), 32'd1);

    // No done after SEND: watchdog in WAIT_DONE.
    auto_done = 1'b0;
    t0 = tmo_cnt;
    add_req(2, 8'h77, 1'b1);
    expect_beat(2, 8'h77);
    wait_beats("nodone", 20);
    wait_tmo("nodone", 60);
    chk("nodone_tmo_state", 32'(o_state), 32'd2);
    chk("nodone_tmo_cycle", 32'(cyc), 32'(dv_cyc + TO));
    @(negedge i_clk);
    chk("nodone_released_grant", 32'(o_grant), 32'd0);
    chk("nodone_released_busy", 32'(o_busy), 32'd0);
    // Stray done while IDLE must not start anything.
    @(posedge i_clk);
    #1 i_TX_Done = 1'b1;
    @(posedge i_clk);
    #1 i_TX_Done = 1'b0;
    @(negedge i_clk);
    chk("stray_done_busy", 32'(o_busy), 32'd0);
    chk("nodone_tmo_count", 32'(tmo_cnt - t0), 32'd1);

    // Done lands exactly in the watchdog cycle: done wins.
    auto_done = 1'b1;
    done_lat  = TO;
    t0 = tmo_cnt;
    add_req(1, 8'h66, 1'b1);
    expect_beat(1, 8'h66);
    wait_drain("coincide", 80);
    chk("coincide_done_cycle", 32'(done_cyc), 32'(dv_cyc + TO));
    chk("coincide_tmo_count", 32'(tmo_cnt - t0), 32'd0);
    chk("coincide_grant", 32'(o_grant), 32'd0);

    // Asynchronous reset while waiting for done.
    auto_done = 1'b0;
    done_lat  = 3;
    add_req(2, 8'h99, 1'b1);
    expect_beat(2, 8'h99);
    wait_beats("midrst", 20);
    repeat (2) @(negedge i_clk);
    chk("midrst_pre_busy", 32'(o_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    add_req(3, 8'hBB, 1'b1);
    add_req(0, 8'hAA, 1'b1);
    expect_beat(0, 8'hAA);
    expect_beat(3, 8'hBB);
    auto_done = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wait_drain("midrst", 100);

    for (int k = 0; k < NR; k++) begin
      chk($sformatf("req%0d_consumed", k), 32'(rq_rd[k]), 32'(rq_cnt[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UARTTX (range 2..8).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 651, meaning the UART bit period in i_clk cycles, matching the UARTTX instance.
REQ-003 The block SHALL have parameter TIMEOUT_CLKS, default 16*CLKS_PER_BIT, meaning the watchdog limit in cycles.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_req_valid, input, NUM_REQ bits: per-requester byte available.
REQ-007 The block SHALL have port i_req_byte, input, 8*NUM_REQ bits: requester k's byte in bits [8k+7:8k].
REQ-008 The block SHALL have port i_req_last, input, NUM_REQ bits: the presented byte ends requester k's packet.
REQ-009 The block SHALL have port o_req_ready, output, NUM_REQ bits: one-cycle, one-hot accept pulse; the byte is consumed when valid and ready are both high.
REQ-010 The block SHALL have port o_TX_Byte, output, 8 bits: the byte driven to UARTTX i_TX_Byte.
REQ-011 The block SHALL have port o_TX_DV, output, 1 bit: one-cycle load strobe to UARTTX i_TX_DV.
REQ-012 The block SHALL have port i_TX_Done, input, 1 bit: UARTTX o_TX_Done.
REQ-013 The block SHALL have port o_grant, output, NUM_REQ bits: one-hot current owner; all zeros when there is no owner.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse when the watchdog fires.

Function
REQ-016 The block SHALL implement the FSM states IDLE, SEND, WAIT_DONE and HOLD.
REQ-017 In IDLE, when any i_req_valid bit is high, the block SHALL pick the winner round-robin, searching from the index after the last released owner, and go to SEND; o_grant SHALL be valid from the SEND cycle.
REQ-018 In SEND (exactly one cycle), the block SHALL drive o_TX_DV=1, o_TX_Byte=winner byte and o_req_ready[winner]=1, capture the winner's i_req_last, and go to WAIT_DONE.
REQ-019 Latency SHALL be: valid seen in IDLE at cycle n gives o_TX_DV at cycle n+1.
REQ-020 In WAIT_DONE, on i_TX_Done=1 the block SHALL go to IDLE if the captured last=1 (releasing the owner and advancing the pointer), otherwise to HOLD.
REQ-021 In HOLD, only the owner's valid SHALL be considered; owner valid goes to SEND with the same grant, and other requesters' valids SHALL be ignored.
REQ-022 The watchdog SHALL count cycles spent in WAIT_DONE or HOLD, clear on every state entry, and, on reaching TIMEOUT_CLKS, pulse o_timeout, release the owner, advance the pointer and go to IDLE.
REQ-023 If i_TX_Done and the timeout coincide, i_TX_Done SHALL win.
REQ-024 A valid that drops without a ready pulse SHALL be allowed; the block SHALL never sample a requester outside IDLE/HOLD arbitration.
REQ-025 An i_TX_Done seen in IDLE, SEND or HOLD SHALL be ignored.
REQ-026 The block SHALL assert o_TX_DV at most once per i_TX_Done (single byte outstanding).
REQ-027 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-028 Asserting i_rst_n=0 at any time, including mid-byte, SHALL asynchronously force state IDLE, o_TX_DV=0, o_req_ready=0, o_grant=0, o_busy=0, o_timeout=0, o_TX_Byte=8'h00, watchdog=0 and pointer=NUM_REQ-1, so that requester 0 wins first.
REQ-029 After reset release, the first arbitration SHALL occur no earlier than the first rising edge with i_rst_n=1.

Structure
REQ-030 The shared package uart_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT and timeout multiplier constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant), purely combinational.

Verification
REQ-032 The bench SHALL cover: reset release, then only req0 valid with 8'hF5 and last=1 -> o_TX_DV one cycle later with o_TX_Byte=F5, ready0 pulse, o_grant=0001, IDLE after done.
REQ-033 The bench SHALL cover: all 4 valid with last=1 and bytes A0..A3 -> transmit order A0,A1,A2,A3, then A0 again on the next round.
REQ-034 The bench SHALL cover: req1 packet DC,F0,AB with last only on AB while req2 is continuously valid -> req2 byte sent only after AB done.
REQ-035 The bench SHALL cover: req3 sends 3D with last=0 then goes idle -> o_timeout after TIMEOUT_CLKS in HOLD, grant released, pending req0 served next.
REQ-036 The bench SHALL cover: i_TX_Done held low after SEND -> o_timeout pulse, return to IDLE; i_TX_Done coinciding with the timeout -> no timeout.
REQ-037 The bench SHALL cover: i_rst_n low mid WAIT_DONE -> all outputs at reset values in the same cycle, first grant to req0 after release.
